freq_gate_ctrl: RTL and testbench

//  Parametrised gate/sequence controller for the frequency meter, running on the system clock.

---
 rtl/freq_gate_ctrl_pkg.sv | 5 +
 rtl/freq_gate_ctrl_if.sv | 17 +
 rtl/freq_gate_ctrl_gate_timer.sv | 18 +
 rtl/freq_gate_ctrl.sv | 91 +++++++++
 tb/tb_freq_gate_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/freq_gate_ctrl_pkg.sv
// freq_gate_ctrl_pkg: shared state encoding and gate range codes for the frequency meter blocks
package freq_gate_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, COUNT = 2'd2, LATCH = 2'd3} state_t;
  localparam logic [1:0] RANGE_1S = 2'd0, RANGE_100MS = 2'd1, RANGE_10MS = 2'd2, RANGE_1MS = 2'd3;
endpackage

// File: rtl/freq_gate_ctrl_if.sv
// freq_gate_ctrl_if: control requests and sequencing strobes between the meter host and the gate controller
interface freq_gate_ctrl_if;
  logic       start;
  logic       cont_mode;
  logic       abort;
  logic [1:0] gate_sel;
  logic       count_en;
  logic       latch_en;
  logic       clear;
  logic       done;
  logic       busy;
  logic [1:0] gate_range;
  modport master (output start, cont_mode, abort, gate_sel,
                  input  count_en, latch_en, clear, done, busy, gate_range);
  modport slave  (input  start, cont_mode, abort, gate_sel,
                  output count_en, latch_en, clear, done, busy, gate_range);
endinterface

// File: rtl/freq_gate_ctrl_gate_timer.sv
// gate_timer: loadable down-counter that parks at zero instead of wrapping
module gate_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: CLEAR -> COUNT -> LATCH sequencer for the frequency meter counter/latch datapath
module freq_gate_ctrl
  import freq_gate_ctrl_pkg::*;
#(
  parameter int GATE0_CYC = 50_000_000,
  parameter int GATE1_CYC = 5_000_000,
  parameter int GATE2_CYC = 500_000,
  parameter int GATE3_CYC = 50_000,
  parameter int CLR_CYC   = 2,
  parameter int CNT_W     = 26
) (
  input logic            clk,
  input logic            rst_n,
  freq_gate_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] CLR_LD = CNT_W'(CLR_CYC - 1);
  state_t           r_state, w_next;
  logic             r_clear, r_count, r_latch, r_busy;
  logic [1:0]       r_range;
  logic             w_load, w_dec, w_sample, w_zero;
  logic [CNT_W-1:0] w_load_val, w_gate_ld;
  always_comb
    w_gate_ld = r_range == RANGE_1S    ? CNT_W'(GATE0_CYC - 1) :
                r_range == RANGE_100MS ? CNT_W'(GATE1_CYC - 1) :
                r_range == RANGE_10MS  ? CNT_W'(GATE2_CYC - 1) : CNT_W'(GATE3_CYC - 1);
  // abort outranks every other transition, including the timer terminal
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_sample   = 1'b0;
    w_load_val = CLR_LD;
    case (r_state)
      IDLE:
        if (!bus.abort && (bus.start || bus.cont_mode)) begin
          w_next   = CLEAR;
          w_load   = 1'b1;
          w_sample = 1'b1;
        end
      CLEAR:
        if (bus.abort) w_next = IDLE;
        else if (w_zero) begin
          w_next     = COUNT;
          w_load     = 1'b1;
          w_load_val = w_gate_ld;
        end else w_dec = 1'b1;
      COUNT:
        if (bus.abort) w_next = IDLE;
        else if (w_zero) w_next = LATCH;
        else w_dec = 1'b1;
      LATCH:
        if (bus.cont_mode && !bus.abort) begin
          w_next   = CLEAR;
          w_load   = 1'b1;
          w_sample = 1'b1;
        end else w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  gate_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_dec      (w_dec),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );
  // outputs are decoded from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_clear <= 1'b0;
      r_count <= 1'b0;
      r_latch <= 1'b0;
      r_busy  <= 1'b0;
      r_range <= RANGE_1S;
    end else begin
      r_state <= w_next;
      r_clear <= (w_next == CLEAR);
      r_count <= (w_next == COUNT);
      r_latch <= (w_next == LATCH);
      r_busy  <= (w_next != IDLE);
      if (w_sample) r_range <= bus.gate_sel;
    end
  assign bus.clear      = r_clear;
  assign bus.count_en   = r_count;
  assign bus.latch_en   = r_latch;
  assign bus.done       = r_latch;
  assign bus.busy       = r_busy;
  assign bus.gate_range = r_range;
endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb_freq_gate_ctrl: directed scenarios plus random stimulus checked against an offset-based reference model
module tb_freq_gate_ctrl;
  localparam int CLR = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  freq_gate_ctrl_if bus ();
  freq_gate_ctrl #(
    .GATE0_CYC(8), .GATE1_CYC(4), .GATE2_CYC(2), .GATE3_CYC(1), .CLR_CYC(CLR), .CNT_W(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  function automatic int glen(input logic [1:0] s);
    return s == 2'd0 ? 8 : s == 2'd1 ? 4 : s == 2'd2 ? 2 : 1;
  endfunction
  // model: a measurement is an offset from its start edge; phases follow from offset ranges
  bit         m_act;
  int         m_off, m_g;
  logic [1:0] m_rng;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_act <= 1'b0; m_off <= 0; m_g <= 0; m_rng <= 2'd0;
    end else if (!m_act) begin
      if (!bus.abort && (bus.start || bus.cont_mode)) begin
        m_act <= 1'b1; m_off <= 0; m_g <= glen(bus.gate_sel); m_rng <= bus.gate_sel;
      end
    end else if (bus.abort) m_act <= 1'b0;
    else if (m_off == CLR + m_g) begin
      if (bus.cont_mode) begin
        m_off <= 0; m_g <= glen(bus.gate_sel); m_rng <= bus.gate_sel;
      end else m_act <= 1'b0;
    end else m_off <= m_off + 1;
  logic [6:0] obs, exp_v;
  logic       m_lat;
  always_comb begin
    obs   = {bus.clear, bus.count_en, bus.latch_en, bus.done, bus.busy, bus.gate_range};
    m_lat = m_act && (m_off == CLR + m_g);
    exp_v = {m_act && m_off < CLR, m_act && m_off >= CLR && m_off < CLR + m_g, m_lat, m_lat, m_act, m_rng};
  end
  task automatic drive(input logic s, input logic c, input logic a, input logic [1:0] sel);
    bus.start = s; bus.cont_mode = c; bus.abort = a; bus.gate_sel = sel;
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 2'd3);
    tick(); tick();
    checks++;
    if (obs !== 7'd0) begin errors++; $display("FAIL reset_hold got=%b want=%b", obs, 7'd0); end
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== 7'd0) begin errors++; $display("FAIL reset_release got=%b want=%b", obs, 7'd0); end
  endtask
  task automatic test_single_shot();
    logic [6:0] want;
    drive(1'b1, 1'b0, 1'b0, 2'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    for (int k = 1; k <= 12; k++) begin
      want = {k <= 2, k >= 3 && k <= 10, k == 11, k == 11, k <= 11, 2'd0};
      checks += 2;
      if (obs !== want) begin errors++; $display("FAIL single_shot k=%0d got=%b want=%b", k, obs, want); end
      if (obs !== exp_v) begin errors++; $display("FAIL single_shot_model k=%0d got=%b want=%b", k, obs, exp_v); end
      tick();
    end
  endtask
  task automatic test_min_gate();
    logic [6:0] want;
    drive(1'b1, 1'b0, 1'b0, 2'd3);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd3);
    for (int k = 1; k <= 6; k++) begin
      want = {k <= 2, k == 3, k == 4, k == 4, k <= 4, 2'd3};
      checks++;
      if (obs !== want) begin errors++; $display("FAIL min_gate k=%0d got=%b want=%b", k, obs, want); end
      tick();
    end
  endtask
  task automatic test_continuous();
    int lat[$];
    drive(1'b0, 1'b1, 1'b0, 2'd1);
    tick();
    for (int k = 1; k <= 27; k++) begin
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL continuous k=%0d got=%b want=%b", k, obs, exp_v); end
      if (bus.latch_en) lat.push_back(k);
      if (k == 13) begin
        checks++;
        if (bus.gate_range !== 2'd1) begin errors++; $display("FAIL cont_range_hold got=%0d want=1", bus.gate_range); end
      end
      if (k == 16) begin
        checks++;
        if (bus.gate_range !== 2'd2) begin errors++; $display("FAIL cont_range_new got=%0d want=2", bus.gate_range); end
      end
      if (k == 11) bus.gate_sel = 2'd2;
      if (k == 20) bus.cont_mode = 1'b0;
      tick();
    end
    checks++;
    if (lat.size() != 4 || lat[0] != 7 || lat[1] != 14 || lat[2] != 19 || lat[3] != 24) begin
      errors++;
      $display("FAIL cont_latch_cycles got=%p want=7,14,19,24", lat);
    end
  endtask
  task automatic test_abort();
    int dones = 0;
    drive(1'b1, 1'b0, 1'b0, 2'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL abort_model k=%0d got=%b want=%b", k, obs, exp_v); end
      if (k >= 6) begin
        checks++;
        if (obs[6:2] !== 5'd0) begin errors++; $display("FAIL abort_idle k=%0d got=%b want=00000", k, obs[6:2]); end
      end
      dones += int'(bus.done);
      bus.start = (k == 4);
      bus.abort = (k == 5);
      tick();
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL abort_no_done got=%0d want=0", dones); end
  endtask
  task automatic test_async_reset();
    drive(1'b1, 1'b0, 1'b0, 2'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd1);
    repeat (3) tick();
    checks++;
    if (bus.count_en !== 1'b1) begin errors++; $display("FAIL async_pre count_en got=%b want=1", bus.count_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 7'd0) begin errors++; $display("FAIL async_reset got=%b want=%b", obs, 7'd0); end
    @(negedge clk);
    rst_n = 1'b1;
    test_single_shot();
  endtask
  task automatic test_conflicts();
    int lats = 0;
    drive(1'b1, 1'b0, 1'b1, 2'd2);
    tick();
    checks++;
    if (obs[6:2] !== 5'd0) begin errors++; $display("FAIL start_abort got=%b want=00000", obs[6:2]); end
    drive(1'b0, 1'b1, 1'b0, 2'd2);
    tick();
    bus.cont_mode = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL cont_drop k=%0d got=%b want=%b", k, obs, exp_v); end
      lats += int'(bus.latch_en);
      tick();
    end
    checks += 2;
    if (lats != 1) begin errors++; $display("FAIL cont_drop_latches got=%0d want=1", lats); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL cont_drop_idle busy got=%b want=0", bus.busy); end
  endtask
  task automatic test_random();
    bus.cont_mode = 1'b0;
    for (int k = 0; k < 800; k++) begin
      bus.start    = ($urandom_range(7) == 0);
      bus.abort    = ($urandom_range(29) == 0);
      bus.gate_sel = 2'($urandom_range(3));
      if ($urandom_range(39) == 0) bus.cont_mode = ~bus.cont_mode;
      tick();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random k=%0d got=%b want=%b", k, obs, exp_v); end
    end
  endtask
  initial begin
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    test_reset();
    test_single_shot();
    test_min_gate();
    test_continuous();
    test_abort();
    test_async_reset();
    test_conflicts();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
